// File: rtl/rob_pkg.sv
// Shared out-of-order core definitions: default widths, the "no producer" tag
// value and the commit bundle passed from the ROB to the register file and RS.
package rob_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned TAG_W_DEF = 3;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned IDX_W_DEF = $clog2(NREG_DEF);

    // Tag value 0 is reserved: the register holds its committed value.
    localparam int unsigned TAG_READY = 0;

    // 'reg' is a keyword, so the destination field is named rd.
    typedef struct packed {
        logic                 valid;
        logic [IDX_W_DEF-1:0] rd;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  data;
    } commit_t;

endpackage

// File: rtl/rename_lookup.sv
// Per-source operand lookup: x0, same-cycle commit bypass, committed value,
// or the outstanding producer tag, in that priority order.
module rename_lookup
    import rob_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    localparam int unsigned IDX_W = $clog2(NREG)
) (
    input  logic [IDX_W-1:0] src,
    input  logic [XLEN-1:0]  src_val,
    input  logic [TAG_W-1:0] src_tag,
    input  logic             cm_valid,
    input  logic [IDX_W-1:0] cm_reg,
    input  logic [TAG_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_data,
    output logic [XLEN-1:0]  val,
    output logic [TAG_W-1:0] tag
);

    localparam logic [TAG_W-1:0] Ready = TAG_W'(TAG_READY);

    // Priority mux; value is left at 0 when only the tag is meaningful.
    always_comb begin
        val = '0;
        tag = Ready;
        if (src == '0) begin
            val = '0;
        end else if (cm_valid && (cm_reg == src) && (src_tag == cm_tag)) begin
            val = cm_data;
        end else if (src_tag == Ready) begin
            val = src_val;
        end else begin
            tag = src_tag;
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename-status table. Dispatch reads both
// sources against the pre-rename state and tags rd; commit writes the value
// and clears the tag only if it still names the committing instruction.
module rename_reg_file
    import rob_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    localparam int unsigned IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [IDX_W-1:0] disp_rs1,
    input  logic [IDX_W-1:0] disp_rs2,
    input  logic [IDX_W-1:0] disp_rd,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             cm_valid,
    input  logic [IDX_W-1:0] cm_reg,
    input  logic [TAG_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_data,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_val1,
    output logic [XLEN-1:0]  out_val2,
    output logic [TAG_W-1:0] out_tag1,
    output logic [TAG_W-1:0] out_tag2,
    output logic [IDX_W:0]   pending_cnt
);

    localparam logic [TAG_W-1:0] Ready = TAG_W'(TAG_READY);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [TAG_W-1:0] tags_q [NREG];
    logic [TAG_W-1:0] tags_d [NREG];
    logic [IDX_W:0]   cnt_q, cnt_d;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_val1_q, out_val2_q;
    logic [TAG_W-1:0] out_tag1_q, out_tag2_q;

    logic [XLEN-1:0]  lk_val1, lk_val2;
    logic [TAG_W-1:0] lk_tag1, lk_tag2;

    logic do_rename, cm_write, cm_clear, lookup_en;

    rename_lookup #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .TAG_W (TAG_W)
    ) u_lookup_rs1 (
        .src      (disp_rs1),
        .src_val  (regs_q[disp_rs1]),
        .src_tag  (tags_q[disp_rs1]),
        .cm_valid (cm_valid),
        .cm_reg   (cm_reg),
        .cm_tag   (cm_tag),
        .cm_data  (cm_data),
        .val      (lk_val1),
        .tag      (lk_tag1)
    );

    rename_lookup #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .TAG_W (TAG_W)
    ) u_lookup_rs2 (
        .src      (disp_rs2),
        .src_val  (regs_q[disp_rs2]),
        .src_tag  (tags_q[disp_rs2]),
        .cm_valid (cm_valid),
        .cm_reg   (cm_reg),
        .cm_tag   (cm_tag),
        .cm_data  (cm_data),
        .val      (lk_val2),
        .tag      (lk_tag2)
    );

    // Decode the cycle's actions; a clear only counts if it removes a live tag.
    always_comb begin
        lookup_en = disp_valid && !flush;
        do_rename = lookup_en && (disp_rd != '0) && (disp_tag != Ready);
        cm_write  = cm_valid && (cm_reg != '0);
        cm_clear  = cm_write && (cm_tag != Ready) && (tags_q[cm_reg] == cm_tag);
    end

    // Next state for register values, tags and the incremental pending count.
    always_comb begin
        regs_d = regs_q;
        tags_d = tags_q;
        cnt_d  = cnt_q;
        // Commit data is never blocked: the committing instruction is older.
        if (cm_write) begin
            regs_d[cm_reg] = cm_data;
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                tags_d[i] = Ready;
            end
            cnt_d = '0;
        end else begin
            if (cm_clear) begin
                tags_d[cm_reg] = Ready;
            end
            // Rename comes after the clear so it wins on the same register.
            if (do_rename) begin
                tags_d[disp_rd] = disp_tag;
            end
            if (do_rename && (tags_q[disp_rd] == Ready)) begin
                cnt_d = cnt_d + (IDX_W + 1)'(1);
            end
            if (cm_clear && !(do_rename && (disp_rd == cm_reg))) begin
                cnt_d = cnt_d - (IDX_W + 1)'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                tags_q[i] <= Ready;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            tags_q <= tags_d;
            cnt_q  <= cnt_d;
        end
    end

    // Registered lookup results; held while no dispatch is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_val1_q  <= '0;
            out_val2_q  <= '0;
            out_tag1_q  <= Ready;
            out_tag2_q  <= Ready;
        end else begin
            out_valid_q <= lookup_en;
            if (lookup_en) begin
                out_val1_q <= lk_val1;
                out_val2_q <= lk_val2;
                out_tag1_q <= lk_tag1;
                out_tag2_q <= lk_tag2;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_val1    = out_val1_q;
    assign out_val2    = out_val2_q;
    assign out_tag1    = out_tag1_q;
    assign out_tag2    = out_tag2_q;
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed scenarios followed by random traffic,
// compared each cycle against an array-based reference model.
module tb_rename_reg_file;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 3;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic [IDX_W-1:0] disp_rs1, disp_rs2, disp_rd;
    logic [TAG_W-1:0] disp_tag;
    logic             cm_valid;
    logic [IDX_W-1:0] cm_reg;
    logic [TAG_W-1:0] cm_tag;
    logic [XLEN-1:0]  cm_data;
    logic             out_valid;
    logic [XLEN-1:0]  out_val1, out_val2;
    logic [TAG_W-1:0] out_tag1, out_tag2;
    logic [IDX_W:0]   pending_cnt;

    rename_reg_file #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_rs1    (disp_rs1),
        .disp_rs2    (disp_rs2),
        .disp_rd     (disp_rd),
        .disp_tag    (disp_tag),
        .cm_valid    (cm_valid),
        .cm_reg      (cm_reg),
        .cm_tag      (cm_tag),
        .cm_data     (cm_data),
        .out_valid   (out_valid),
        .out_val1    (out_val1),
        .out_val2    (out_val2),
        .out_tag1    (out_tag1),
        .out_tag2    (out_tag2),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int unsigned m_regs [NREG];
    int unsigned m_tags [NREG];
    int unsigned e_valid, e_val1, e_val2, e_tag1, e_tag2, e_cnt;

    int pass_cnt = 0;
    int total    = 0;

    function automatic void ref_lookup(input int unsigned s, output int unsigned v,
                                       output int unsigned t);
        v = 0;
        t = 0;
        if (s == 0) return;
        if (cm_valid && cm_reg == s && m_tags[s] == cm_tag) begin
            v = cm_data;
        end else if (m_tags[s] == 0) begin
            v = m_regs[s];
        end else begin
            t = m_tags[s];
        end
    endfunction

    // Apply one clock edge of the architectural rules to the model.
    function automatic void ref_step();
        int unsigned v1, t1, v2, t2;
        int unsigned n;
        if (!rst) begin
            foreach (m_regs[i]) begin
                m_regs[i] = 0;
                m_tags[i] = 0;
            end
            e_valid = 0; e_val1 = 0; e_val2 = 0; e_tag1 = 0; e_tag2 = 0;
        end else begin
            ref_lookup(disp_rs1, v1, t1);
            ref_lookup(disp_rs2, v2, t2);
            e_valid = (disp_valid && !flush) ? 1 : 0;
            if (e_valid == 1) begin
                e_val1 = v1; e_tag1 = t1; e_val2 = v2; e_tag2 = t2;
            end
            if (cm_valid && cm_reg != 0) begin
                m_regs[cm_reg] = cm_data;
                if (m_tags[cm_reg] == cm_tag) m_tags[cm_reg] = 0;
            end
            if (flush) begin
                foreach (m_tags[i]) m_tags[i] = 0;
            end else if (disp_valid && disp_rd != 0 && disp_tag != 0) begin
                m_tags[disp_rd] = disp_tag;
            end
        end
        n = 0;
        foreach (m_tags[i]) if (m_tags[i] != 0) n++;
        e_cnt = n;
    endfunction

    task automatic chk(input string name, input int unsigned obs, input int unsigned exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Model the coming edge, take it, then compare 1 time unit later.
    task automatic tick(input string name);
        ref_step();
        @(posedge clk);
        #1;
        chk({name, ".valid"}, out_valid, e_valid);
        chk({name, ".tag1"}, out_tag1, e_tag1);
        chk({name, ".tag2"}, out_tag2, e_tag2);
        chk({name, ".cnt"}, pending_cnt, e_cnt);
        if (e_tag1 == 0) chk({name, ".val1"}, out_val1, e_val1);
        if (e_tag2 == 0) chk({name, ".val2"}, out_val2, e_val2);
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; disp_rs1 = 0; disp_rs2 = 0; disp_rd = 0; disp_tag = 0;
        cm_valid = 0; cm_reg = 0; cm_tag = 0; cm_data = 0;
    endtask

    task automatic disp(input int rs1, input int rs2, input int rd, input int tag);
        disp_valid = 1;
        disp_rs1 = IDX_W'(rs1); disp_rs2 = IDX_W'(rs2);
        disp_rd = IDX_W'(rd); disp_tag = TAG_W'(tag);
    endtask

    task automatic commit(input int r, input int t, input int unsigned d);
        cm_valid = 1; cm_reg = IDX_W'(r); cm_tag = TAG_W'(t); cm_data = d;
    endtask

    initial begin
        rst = 0;
        idle();
        #1;
        tick("reset0");
        tick("reset1");
        rst = 1;

        // Initial read of an untouched register and x0.
        disp(5, 0, 0, 0); tick("init_read");

        // Rename r3 to tag 4, then read it.
        idle(); disp(0, 0, 3, 4); tick("rename3");
        idle(); disp(3, 0, 0, 0); tick("lookup3");

        // Same-cycle commit bypass.
        idle(); disp(3, 3, 0, 0); commit(3, 4, 32'hDEADBEEF); tick("bypass3");
        idle(); disp(3, 0, 0, 0); tick("after_bypass3");

        // Stale commit versus newer rename.
        idle(); disp(0, 0, 7, 2); tick("rename7a");
        idle(); disp(0, 0, 7, 5); tick("rename7b");
        idle(); disp(7, 0, 0, 0); commit(7, 2, 32'h11); tick("stale7");
        idle(); disp(7, 0, 7, 6); commit(7, 5, 32'h22); tick("race7");
        idle(); disp(7, 7, 0, 0); tick("lookup7");

        // Self-dependency and writes to x0.
        idle(); disp(9, 0, 9, 3); tick("selfdep9");
        idle(); disp(0, 9, 0, 1); tick("x0_rename");
        idle(); disp(0, 0, 0, 0); commit(0, 0, 32'hFFFF_FFFF); tick("x0_commit");
        idle(); disp(0, 0, 4, 0); tick("tag0_rename");

        // Flush with three pending registers and a commit in the same cycle.
        idle(); disp(0, 0, 2, 1); tick("rename2");
        idle(); disp(2, 9, 11, 7); commit(2, 1, 32'h55); flush = 1; tick("flush");
        idle(); disp(2, 7, 0, 0); tick("post_flush_a");
        idle(); disp(9, 11, 0, 0); tick("post_flush_b");

        // Random traffic over a small register window to force collisions.
        for (int i = 0; i < 400; i++) begin
            int r;
            idle();
            rst = ($urandom_range(0, 79) != 0);
            flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                disp($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 7);
                commit(r, ($urandom_range(0, 3) != 0) ? int'(m_tags[r]) : $urandom_range(0, 7),
                       $urandom);
            end
            tick("rand");
        end
        rst = 1;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Parametrised architectural register file plus rename-status table for the out-of-order core; successor to the fixed 32x32 / 3-bit-tag register file.
- At dispatch, looks up both source operands and returns either the committed value or the producer ROB tag; at the same time, records the new producer tag for rd.
- At commit, writes the register and clears its tag if it still matches.
- Adds same-cycle commit bypass, a flush (mispredict) clear of all tags, and a pending-register counter.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; must be a power of two. Register 0 is hardwired to zero.
- TAG_W, 3, ROB tag width. Tag value 0 is reserved and means "ready / no producer".
- IDX_W, $clog2(NREG), register index width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  mispredict flush; clears all tags.
- disp_valid  in  1  dispatch request this cycle.
- disp_rs1  in  IDX_W  source 1 index.
- disp_rs2  in  IDX_W  source 2 index.
- disp_rd  in  IDX_W  destination index.
- disp_tag  in  TAG_W  ROB tag of the dispatching instruction.
- cm_valid  in  1  commit request.
- cm_reg  in  IDX_W  committed destination.
- cm_tag  in  TAG_W  committed ROB tag.
- cm_data  in  XLEN  committed value.
- out_valid  out  1  lookup result valid; registered.
- out_val1  out  XLEN  source 1 value; meaningful only when out_tag1 == 0.
- out_val2  out  XLEN  source 2 value; meaningful only when out_tag2 == 0.
- out_tag1  out  TAG_W  producer tag for source 1; 0 means ready.
- out_tag2  out  TAG_W  producer tag for source 2; 0 means ready.
- pending_cnt  out  IDX_W+1  number of registers with a nonzero tag.

Behaviour:
- Reset (rst==0 at posedge):
  - All regs become 0 and all tags become 0.
  - out_valid, out_val1/2, out_tag1/2 and pending_cnt become 0.
  - Reset overrides every other input.
- Latency: a lookup presented at posedge N appears on out_* after posedge N, i.e. one cycle.
  - out_valid = disp_valid & ~flush, registered.
  - When out_valid is 0, out_val*/out_tag* hold their previous values.
- Lookup for each source s, evaluated in priority order:
  1. s==0 -> value 0, tag 0.
  2. cm_valid & cm_reg==s & tag[s]==cm_tag -> value cm_data, tag 0 (commit bypass).
  3. tag[s]==0 -> value regs[s], tag 0.
  4. Otherwise -> tag tag[s], value don't-care.
- Sources always see the pre-rename state. If rs==rd in the same dispatch, the instruction gets the old producer, not its own tag.
- Commit:
  - If cm_valid & cm_reg!=0, regs[cm_reg] <= cm_data, unconditionally (flush does not block this; the committing instruction is older).
  - tag[cm_reg] <= 0 only if the current tag[cm_reg]==cm_tag; a stale commit leaves a newer tag intact.
- Rename:
  - If disp_valid & ~flush & disp_rd!=0 & disp_tag!=0, tag[disp_rd] <= disp_tag.
  - Rename beats the commit clear when disp_rd==cm_reg in the same cycle.
  - disp_tag==0 is illegal and is ignored; no rename takes place.
- Flush: all tags <= 0 in the same posedge; no rename that cycle; the commit write to regs still happens.
- pending_cnt:
  - Registered; equals the popcount of nonzero tags after the update.
  - Maintained incrementally: +1 when a renamed rd had tag 0; −1 when a commit clears a tag and no rename hits the same reg.
  - Set to 0 on flush or reset.
  - Never exceeds NREG−1.
- Register 0 is never written and never tagged.

Decomposition:
- Shared package rob_pkg holds:
  - TAG_W and XLEN defaults.
  - The TAG_READY=0 constant.
  - The commit-bundle typedef {valid, reg, tag, data}, reusable by the ROB and RS.
- One natural sub-module, rename_lookup: the combinational per-source lookup/bypass mux, instantiated twice (rs1, rs2).

Test Plan:
- Reset/initial read: rst=0 for 2 cycles, then dispatch rs1=5, rs2=0 -> out_valid=1, out_val1=0, out_tag1=0, out_val2=0, pending_cnt=0.
- Rename then lookup: dispatch rd=3, tag=4; next cycle dispatch rs1=3 -> out_tag1=4, pending_cnt=1.
- Commit bypass: with tag[3]=4, same cycle cm(3, 4, 0xDEADBEEF) and dispatch rs1=3 -> out_tag1=0, out_val1=0xDEADBEEF; afterwards pending_cnt=0.
- Stale commit and rename race:
  - Part 1: tag[7]=2, then rename rd=7 tag=5, then cm(7, 2, 0x11) -> regs[7]=0x11, tag[7] stays 5, lookup returns tag 5.
  - Part 2: simultaneous cm(7, 5) and rename rd=7 tag=6 -> tag[7]=6.
- Self-dependency and x0: dispatch rs1=9, rd=9, tag=3 with tag[9]=0 -> out_tag1=0. Dispatch rd=0, tag=1 -> pending_cnt unchanged and tag[0] stays 0.
- Flush: with 3 pending regs, flush=1 with disp_valid=1 and cm(2, t, 0x55) -> pending_cnt=0, out_valid=0, regs[2]=0x55. All later lookups return tag 0.
